// File: rtl/uart_rx_buffer_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer_pkg
// Shared definitions for the UART receive-side byte buffer:
//   - default byte width and FIFO depth
//   - capture FSM state encoding used by uart_rx_buffer
// ---------------------------------------------------------------------------
package uart_rx_buffer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  // Capture handshake with the receiver's ready / clear-ready pair.
  typedef enum logic [1:0] {
    sIdle  = 2'b00,
    sClear = 2'b01,
    sWait  = 2'b10
  } cap_state_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer_if
// Bundles the receiver-side handshake and the consumer-side show-ahead read
// port of uart_rx_buffer.
//   i_rx_data / i_rx_ready / o_rx_clear : byte handshake with the UART receiver
//   o_data / o_valid / i_read           : show-ahead FIFO head and pop strobe
//   o_count / o_full                    : occupancy status
//   o_overflow / i_clear_overflow       : sticky dropped-byte flag and its clear
// Modports:
//   master : the surrounding logic (receiver + consumer), drives the i_* signals
//   slave  : the buffer itself, drives the o_* signals
// ---------------------------------------------------------------------------
interface uart_rx_buffer_if
  import uart_rx_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_ready;
  logic              o_rx_clear;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_read;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_overflow;
  logic              i_clear_overflow;

  modport master (
    output i_rx_data, i_rx_ready, i_read, i_clear_overflow,
    input  o_rx_clear, o_data, o_valid, o_count, o_full, o_overflow
  );

  modport slave (
    input  i_rx_data, i_rx_ready, i_read, i_clear_overflow,
    output o_rx_clear, o_data, o_valid, o_count, o_full, o_overflow
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Synchronous show-ahead byte FIFO. Full/empty come from the occupancy count,
// so the pointers are free to wrap naturally modulo DEPTH.
// Ports:
//   i_clk, i_reset : clock and asynchronous active-high reset (control only;
//                    the storage array is never reset)
//   push, push_data: write request; accepted when not full, or when full and
//                    a pop happens on the same edge
//   pop            : read request; ignored while empty
//   head           : mem[rd_ptr], combinational; meaningful only when valid=1
//   valid, full    : count != 0, count == DEPTH
//   count          : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module uart_byte_fifo
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign valid = (count != '0);
  assign full  = (count == FULL_COUNT);
  assign rd_en = pop & valid;
  // A pop on the same edge frees the slot the push needs.
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer
// Receive-side byte buffer directly downstream of the UART receiver. Each
// completed byte is taken with a ready / clear-ready handshake, stored in
// uart_byte_fifo, and offered to the consumer through a show-ahead
// valid/read port. Bytes arriving while the FIFO is full (and not being
// drained on the same edge) are dropped and recorded in a sticky overflow.
// Ports:
//   i_clk   : system clock, shared with the receiver
//   i_reset : asynchronous active-high reset, shared with the receiver
//   bus     : uart_rx_buffer_if slave modport (handshake, read port, status)
// ---------------------------------------------------------------------------
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic              i_clk,
  input logic              i_reset,
  uart_rx_buffer_if.slave  bus
);

  cap_state_t state_q;
  cap_state_t state_d;
  logic       capture;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_valid;
  logic       overflow_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= sIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // sWait holds off until the receiver drops ready, so a level that stays
  // high is captured exactly once.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      sIdle: begin
        if (bus.i_rx_ready) begin
          capture = 1'b1;
          state_d = sClear;
        end
      end
      sClear: begin
        state_d = sWait;
      end
      sWait: begin
        if (!bus.i_rx_ready) begin
          state_d = sIdle;
        end
      end
      default: begin
        state_d = sIdle;
      end
    endcase
  end

  assign pop  = bus.i_read & fifo_valid;
  // Full with a simultaneous pop still accepts the byte; only a capture
  // into a full FIFO that is not being drained loses data.
  assign drop = capture & fifo_full & ~pop;

  // Setting wins over a same-cycle clear so no drop event goes unreported.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.i_clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (capture),
    .push_data (bus.i_rx_data),
    .pop       (pop),
    .head      (bus.o_data),
    .valid     (fifo_valid),
    .count     (bus.o_count),
    .full      (fifo_full)
  );

  assign bus.o_rx_clear = (state_q == sClear);
  assign bus.o_valid    = fifo_valid;
  assign bus.o_full     = fifo_full;
  assign bus.o_overflow = overflow_q;

endmodule
